mem_arbiter: RTL and testbench

// - Two-to-one arbiter between the pipeline's instruction-fetch port (I) and data-memory port (D)
//   and the single physical memory port (pmem).
// - Sits directly downstream of cpu_datapath: consumes the IF fetch request (pc_out/mem_read1)
//   and the MEM-stage load/store request, and returns read data and a response pulse to each.
// - Serialises accesses; one pmem transaction is outstanding at a time.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter serialising the I-fetch and D-memory ports onto one pmem port.
// Optional feature: define ARB_ROUND_ROBIN_EN for a round-robin tie-break instead of fixed D-over-I.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_d_req;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_strobe;
  logic              w_done;
  logic              r_rw;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [ADDR_W-1:0] r_pmem_addr;
  logic [DATA_W-1:0] r_pmem_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
`ifdef ARB_ROUND_ROBIN_EN
  logic              r_ptr_i;
`endif

  assign w_d_req  = d_read | d_write;
  assign w_strobe = r_pmem_read | r_pmem_write;
  // A completion only counts once the strobe is actually on the bus.
  assign w_done   = (r_state != ST_IDLE) & w_strobe & pmem_resp;

  // Next-state and grant selection.
  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      ST_IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (w_d_req && i_read) begin
          w_grant_i = r_ptr_i;
          w_grant_d = ~r_ptr_i;
        end else begin
          w_grant_d = w_d_req;
          w_grant_i = i_read;
        end
`else
        w_grant_d = w_d_req;
        w_grant_i = i_read & ~w_d_req;
`endif
        if (w_grant_d) begin
          w_state_next = ST_SERVE_D;
        end else if (w_grant_i) begin
          w_state_next = ST_SERVE_I;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (w_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Latched operands, bus strobes (one cycle after grant) and held read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw         <= 1'b0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_pmem_addr  <= '0;
      r_pmem_wdata <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      if (w_grant_d) begin
        r_pmem_addr  <= d_addr;
        r_pmem_wdata <= d_wdata;
        r_rw         <= d_write;
      end else if (w_grant_i) begin
        r_pmem_addr  <= i_addr;
        r_rw         <= 1'b0;
      end
      r_pmem_read  <= (r_state != ST_IDLE) & ~w_done & ~r_rw;
      r_pmem_write <= (r_state != ST_IDLE) & ~w_done & r_rw;
      if (i_resp) r_i_rdata <= pmem_rdata;
      if (d_resp) r_d_rdata <= pmem_rdata;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ptr_i <= 1'b0;
    else if (w_done) r_ptr_i <= ~r_ptr_i;
  end
`endif

  assign i_resp     = (r_state == ST_SERVE_I) & w_done;
  assign d_resp     = (r_state == ST_SERVE_D) & w_done;
  assign i_rdata    = i_resp ? pmem_rdata : r_i_rdata;
  assign d_rdata    = d_resp ? pmem_rdata : r_d_rdata;
  assign pmem_read  = r_pmem_read;
  assign pmem_write = r_pmem_write;
  assign pmem_addr  = r_pmem_addr;
  assign pmem_wdata = r_pmem_wdata;

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter against a transaction-level model with a behavioural pmem.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_addr, d_addr, pmem_addr;
  logic [DW-1:0] d_wdata, pmem_rdata, i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester intent, current owner of pmem (0 none, 1 I, 2 D) and held data.
  bit            m_i_pend, m_d_pend, m_d_wr, m_rw, ptr_i, gen_en, stray_en;
  logic [AW-1:0] m_i_a, m_d_a, m_addr;
  logic [DW-1:0] m_d_wd, m_wdata, last_i, last_d;
  int            owner, served, lat;
  int            force_lat = -1;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive();
    i_read  = m_i_pend;
    i_addr  = m_i_a;
    d_read  = m_d_pend && !m_d_wr;
    d_write = m_d_pend && m_d_wr;
    d_addr  = m_d_a;
    d_wdata = m_d_wd;
  endtask

  task automatic model_reset();
    owner = 0; served = 0; lat = 0;
    m_i_pend = 0; m_d_pend = 0; m_d_wr = 0;
    last_i = '0; last_d = '0; ptr_i = 0;
  endtask

  // One clock cycle: pmem reply, checks, requester update, arbitration at the edge.
  task automatic step();
    bit exp_strobe, done, win_i, win_d;
    exp_strobe = (owner != 0) && (served >= 1);
    pmem_resp  = 1'b0;
    if (exp_strobe) begin
      if (lat == 0) pmem_resp = 1'b1;
      else lat--;
    end else if (stray_en && owner == 0 && $urandom_range(0, 4) == 0) begin
      pmem_resp = 1'b1;
    end
    pmem_rdata = rnd128();
    #1;
    check_eq("pmem_read", DW'(pmem_read), DW'(exp_strobe && !m_rw));
    check_eq("pmem_write", DW'(pmem_write), DW'(exp_strobe && m_rw));
    if (exp_strobe) begin
      check_eq("pmem_addr", DW'(pmem_addr), DW'(m_addr));
      if (m_rw) check_eq("pmem_wdata", pmem_wdata, m_wdata);
    end
    done = exp_strobe && pmem_resp;
    check_eq("i_resp", DW'(i_resp), DW'(done && owner == 1));
    check_eq("d_resp", DW'(d_resp), DW'(done && owner == 2));
    if (done && owner == 1) last_i = pmem_rdata;
    if (done && owner == 2) last_d = pmem_rdata;
    check_eq("i_rdata", i_rdata, last_i);
    check_eq("d_rdata", d_rdata, last_d);
    if (done) begin
      if (owner == 1) m_i_pend = 0;
      else            m_d_pend = 0;
      ptr_i = !ptr_i;
    end
    if (!m_i_pend) m_i_a = AW'($urandom);
    if (!m_d_pend) begin
      m_d_a  = AW'($urandom);
      m_d_wd = rnd128();
      m_d_wr = 1'($urandom_range(0, 1));
    end
    if (gen_en) begin
      if (!m_i_pend && $urandom_range(0, 2) == 0) m_i_pend = 1;
      if (!m_d_pend && $urandom_range(0, 2) == 0) m_d_pend = 1;
    end
    if (done) begin
      owner = 0;
    end else if (owner == 0) begin
      win_d = m_d_pend;
      win_i = m_i_pend && !m_d_pend;
`ifdef ARB_ROUND_ROBIN_EN
      if (m_d_pend && m_i_pend) begin
        win_i = ptr_i;
        win_d = !ptr_i;
      end
`endif
      if (win_d) begin
        owner = 2; m_addr = m_d_a; m_rw = m_d_wr; m_wdata = m_d_wd;
      end else if (win_i) begin
        owner = 1; m_addr = m_i_a; m_rw = 0;
      end
      served = 0;
      lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
    end else begin
      served++;
    end
    drive();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input string tag);
    int n;
    n = 0;
    while ((m_i_pend || m_d_pend || owner != 0) && n < 60) begin
      step();
      n++;
    end
    check_eq(tag, DW'(m_i_pend || m_d_pend || owner != 0), DW'(0));
  endtask

  initial begin
    int n;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    gen_en = 0;
    stray_en = 0;
    model_reset();
    m_i_a = '0; m_d_a = '0; m_d_wd = '0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pmem_read", DW'(pmem_read), DW'(0));
    check_eq("rst_pmem_write", DW'(pmem_write), DW'(0));
    check_eq("rst_pmem_addr", DW'(pmem_addr), DW'(0));
    check_eq("rst_pmem_wdata", pmem_wdata, DW'(0));
    check_eq("rst_resp", DW'({i_resp, d_resp}), DW'(0));
    rst_n = 1'b1;

    // Lone I read with a 3-cycle pmem.
    m_i_pend = 1; m_i_a = 16'h0040; force_lat = 2;
    run_until_idle("idle_after_i_read");
    // Lone D write.
    m_d_pend = 1; m_d_wr = 1; m_d_a = 16'h1000; m_d_wd = 128'h1234; force_lat = -1;
    run_until_idle("idle_after_d_write");
    // Simultaneous I and D requests.
    m_i_pend = 1; m_i_a = 16'h0200; m_d_pend = 1; m_d_wr = 0; m_d_a = 16'h0300;
    run_until_idle("idle_after_tie");
    // I in service while the idle D side toggles its address, then D requests.
    m_i_pend = 1; m_i_a = 16'h0404; force_lat = 3;
    step(); step(); step();
    m_d_pend = 1; m_d_wr = 0;
    run_until_idle("idle_after_late_d");
    force_lat = -1;

    // Random traffic with stray pmem_resp pulses while idle.
    gen_en = 1; stray_en = 1;
    repeat (600) step();
    gen_en = 0; stray_en = 0;
    run_until_idle("idle_after_random");

    // Reset in the middle of a D write.
    m_d_pend = 1; m_d_wr = 1; m_d_a = 16'h1000; m_d_wd = 128'h1234; force_lat = 20;
    n = 0;
    while (!(owner == 2 && served >= 1) && n < 10) begin
      step();
      n++;
    end
    check_eq("reach_serve_d", DW'(owner == 2 && served >= 1), DW'(1));
    rst_n = 1'b0;
    pmem_resp = 1'b0;
    #1;
    check_eq("midrst_pmem_write", DW'(pmem_write), DW'(0));
    check_eq("midrst_pmem_read", DW'(pmem_read), DW'(0));
    check_eq("midrst_d_resp", DW'(d_resp), DW'(0));
    model_reset();
    force_lat = -1;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray_en = 1;
    repeat (12) step();
    stray_en = 0;
    m_i_pend = 1; m_i_a = 16'h0040;
    run_until_idle("idle_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
